ex_stage: RTL and testbench

- Execute stage that consumes the ID/EX pipeline register outputs and computes the ALU result, branch resolution and store data.
- Contains a 32-cycle iterative multiplier. While it runs, the stage stalls the front end.
- Registers its results into the EX/MEM boundary, which the memory stage consumes directly.

---
 rtl/ex_stage.sv | 206 ++++++++++++++++++++
 tb/tb_ex_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch resolution and an iterative shift-add multiplier,
// registering results into the EX/MEM boundary.
module ex_stage #(
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [5:0]  opcode_in,
  input  logic [31:0] alu_a_in,
  input  logic [31:0] alu_b_in,
  input  logic [15:0] imm_in,
  input  logic [31:0] pc_in,
  input  logic [4:0]  dest_reg_in,
  input  logic        branch_in,
  input  logic        call_in,
  input  logic        ret_in,
  input  logic        pop_in,
  input  logic        mem_to_reg_in,
  input  logic        mem_src_in,
  input  logic        load_imm_in,
  input  logic        reg_write_in,
  input  logic        mem_write_in,
  input  logic        mem_read_in,
  input  logic        flush,
  output logic        stall_out,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        valid_out,
  output logic [31:0] result_out,
  output logic [31:0] store_data_out,
  output logic [4:0]  dest_reg_out,
  output logic [31:0] pc_out,
  output logic        branch_out,
  output logic        call_out,
  output logic        ret_out,
  output logic        pop_out,
  output logic        mem_to_reg_out,
  output logic        mem_src_out,
  output logic        load_imm_out,
  output logic        reg_write_out,
  output logic        mem_write_out,
  output logic        mem_read_out
);

  localparam logic [5:0] OP_ADD = 6'd0;
  localparam logic [5:0] OP_SUB = 6'd1;
  localparam logic [5:0] OP_AND = 6'd2;
  localparam logic [5:0] OP_OR  = 6'd3;
  localparam logic [5:0] OP_XOR = 6'd4;
  localparam logic [5:0] OP_SLL = 6'd5;
  localparam logic [5:0] OP_SRL = 6'd6;
  localparam logic [5:0] OP_SRA = 6'd7;
  localparam logic [5:0] OP_SLT = 6'd8;
  localparam logic [5:0] OP_MUL = 6'd9;
  localparam logic [5:0] OP_BEQ = 6'd10;
  localparam logic [5:0] OP_BNE = 6'd11;

  localparam logic [5:0] LAST_ITER = 6'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mul_state_t;

  mul_state_t  state;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] acc;
  logic [5:0]  count;

  logic [31:0] imm_sext;
  logic [4:0]  shamt;
  logic [31:0] alu_result;
  logic        branch_cond;
  logic        mul_start;
  logic        load_bubble;

  assign imm_sext = {{16{imm_in[15]}}, imm_in};
  assign shamt    = alu_b_in[4:0];

  always_comb begin
    alu_result = '0;
    case (opcode_in)
      OP_ADD:         alu_result = alu_a_in + alu_b_in;
      OP_SUB:         alu_result = alu_a_in - alu_b_in;
      OP_AND:         alu_result = alu_a_in & alu_b_in;
      OP_OR:          alu_result = alu_a_in | alu_b_in;
      OP_XOR:         alu_result = alu_a_in ^ alu_b_in;
      OP_SLL:         alu_result = alu_a_in << shamt;
      OP_SRL:         alu_result = alu_a_in >> shamt;
      OP_SRA:         alu_result = $signed(alu_a_in) >>> shamt;
      OP_SLT:         alu_result = {31'd0, $signed(alu_a_in) < $signed(alu_b_in)};
      // The multiply result is only captured in the DONE cycle, when acc is final.
      OP_MUL:         alu_result = acc;
      OP_BEQ, OP_BNE: alu_result = alu_a_in - alu_b_in;
      default:        alu_result = alu_a_in + imm_sext;
    endcase
    if (load_imm_in) begin
      alu_result = {imm_in, 16'h0000};
    end
  end

  always_comb begin
    branch_cond = 1'b0;
    case (opcode_in)
      OP_BEQ:  branch_cond = (alu_a_in == alu_b_in);
      OP_BNE:  branch_cond = (alu_a_in != alu_b_in);
      default: branch_cond = 1'b0;
    endcase
  end

  // Acceptance stalls in the same cycle; a flush during BUSY releases the stall at once.
  assign mul_start     = valid_in & (opcode_in == OP_MUL) & ~flush & (state == IDLE);
  assign stall_out     = mul_start | ((state == BUSY) & ~flush);
  assign branch_taken  = valid_in & branch_in & ~flush & ~stall_out & branch_cond;
  assign branch_target = pc_in + 32'd1 + imm_sext;
  assign load_bubble   = flush | stall_out | ~valid_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mul_start) begin
            state  <= BUSY;
            mcand  <= alu_a_in;
            mplier <= alu_b_in;
            acc    <= '0;
            count  <= '0;
          end
        end
        BUSY: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc    <= acc + (mplier[0] ? mcand : '0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 6'd1;
            if (count == LAST_ITER) begin
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out      <= 1'b0;
      result_out     <= '0;
      store_data_out <= '0;
      dest_reg_out   <= '0;
      pc_out         <= '0;
      branch_out     <= 1'b0;
      call_out       <= 1'b0;
      ret_out        <= 1'b0;
      pop_out        <= 1'b0;
      mem_to_reg_out <= 1'b0;
      mem_src_out    <= 1'b0;
      load_imm_out   <= 1'b0;
      reg_write_out  <= 1'b0;
      mem_write_out  <= 1'b0;
      mem_read_out   <= 1'b0;
    end else if (load_bubble) begin
      valid_out      <= 1'b0;
      branch_out     <= 1'b0;
      call_out       <= 1'b0;
      ret_out        <= 1'b0;
      pop_out        <= 1'b0;
      mem_to_reg_out <= 1'b0;
      mem_src_out    <= 1'b0;
      load_imm_out   <= 1'b0;
      reg_write_out  <= 1'b0;
      mem_write_out  <= 1'b0;
      mem_read_out   <= 1'b0;
    end else begin
      valid_out      <= 1'b1;
      result_out     <= alu_result;
      store_data_out <= alu_b_in;
      dest_reg_out   <= dest_reg_in;
      pc_out         <= pc_in;
      branch_out     <= branch_in;
      call_out       <= call_in;
      ret_out        <= ret_in;
      pop_out        <= pop_in;
      mem_to_reg_out <= mem_to_reg_in;
      mem_src_out    <= mem_src_in;
      load_imm_out   <= load_imm_in;
      reg_write_out  <= reg_write_in & ~branch_taken;
      mem_write_out  <= mem_write_in;
      mem_read_out   <= mem_read_in;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed corner cases followed by random
// instructions checked against a behavioural reference model.
module tb_ex_stage;

  localparam int unsigned MUL_CYCLES = 32;
  localparam logic [9:0] C_BR = 10'h200;
  localparam logic [9:0] C_LI = 10'h008;
  localparam logic [9:0] C_RW = 10'h004;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid_in, flush;
  logic [5:0]  opcode_in;
  logic [31:0] alu_a_in, alu_b_in, pc_in;
  logic [15:0] imm_in;
  logic [4:0]  dest_reg_in;
  logic        branch_in, call_in, ret_in, pop_in, mem_to_reg_in, mem_src_in;
  logic        load_imm_in, reg_write_in, mem_write_in, mem_read_in;
  logic        stall_out, branch_taken, valid_out;
  logic [31:0] branch_target, result_out, store_data_out, pc_out;
  logic [4:0]  dest_reg_out;
  logic        branch_out, call_out, ret_out, pop_out, mem_to_reg_out, mem_src_out;
  logic        load_imm_out, reg_write_out, mem_write_out, mem_read_out;
  logic [9:0]  ctrl_out;

  ex_stage #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .opcode_in(opcode_in),
    .alu_a_in(alu_a_in), .alu_b_in(alu_b_in), .imm_in(imm_in), .pc_in(pc_in),
    .dest_reg_in(dest_reg_in), .branch_in(branch_in), .call_in(call_in),
    .ret_in(ret_in), .pop_in(pop_in), .mem_to_reg_in(mem_to_reg_in),
    .mem_src_in(mem_src_in), .load_imm_in(load_imm_in), .reg_write_in(reg_write_in),
    .mem_write_in(mem_write_in), .mem_read_in(mem_read_in), .flush(flush),
    .stall_out(stall_out), .branch_taken(branch_taken), .branch_target(branch_target),
    .valid_out(valid_out), .result_out(result_out), .store_data_out(store_data_out),
    .dest_reg_out(dest_reg_out), .pc_out(pc_out), .branch_out(branch_out),
    .call_out(call_out), .ret_out(ret_out), .pop_out(pop_out),
    .mem_to_reg_out(mem_to_reg_out), .mem_src_out(mem_src_out),
    .load_imm_out(load_imm_out), .reg_write_out(reg_write_out),
    .mem_write_out(mem_write_out), .mem_read_out(mem_read_out)
  );

  assign ctrl_out = {branch_out, call_out, ret_out, pop_out, mem_to_reg_out,
                     mem_src_out, load_imm_out, reg_write_out, mem_write_out, mem_read_out};

  typedef struct {
    logic [31:0] result;
    logic        chk_result;
    logic [31:0] store;
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [9:0]  ctrl;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_model(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [15:0] imm,
                                            input logic li);
    logic [4:0]  sh;
    logic [31:0] fill;
    logic [63:0] mask;
    logic [63:0] prod;
    sh = b[4:0];
    if (li) return {imm, 16'h0000};
    case (op)
      6'd0: return a + b;
      6'd1: return a - b;
      6'd2: return a & b;
      6'd3: return a | b;
      6'd4: return a ^ b;
      6'd5: return a << sh;
      6'd6: return a >> sh;
      6'd7: begin
        fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
        return (a >> sh) | fill;
      end
      6'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd9: begin
        mask = (MUL_CYCLES >= 32) ? 64'hFFFF_FFFF : ((64'd1 << MUL_CYCLES) - 64'd1);
        prod = {32'd0, a} * {32'd0, b & mask[31:0]};
        return prod[31:0];
      end
      6'd10, 6'd11: return 32'd0;
      default: return a + {{16{imm[15]}}, imm};
    endcase
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (valid_out === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_valid_out", 32'(valid_out), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.chk_result) check("result_out", result_out, mon_e.result);
          check("store_data_out", store_data_out, mon_e.store);
          check("pc_out", pc_out, mon_e.pc);
          check("dest_reg_out", 32'(dest_reg_out), 32'(mon_e.dest));
          check("ctrl_out", 32'(ctrl_out), 32'(mon_e.ctrl));
        end
      end else begin
        check("bubble_ctrl", 32'(ctrl_out), 32'd0);
      end
    end
  end

  task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [15:0] imm, input logic [31:0] pc,
                       input logic [4:0] dest, input logic [9:0] ctrl, input logic fl);
    valid_in = v; opcode_in = op; alu_a_in = a; alu_b_in = b; imm_in = imm;
    pc_in = pc; dest_reg_in = dest; flush = fl;
    {branch_in, call_in, ret_in, pop_in, mem_to_reg_in, mem_src_in,
     load_imm_in, reg_write_in, mem_write_in, mem_read_in} = ctrl;
  endtask

  task automatic bubble();
    drive(1'b0, 6'd0, 32'd0, 32'd0, 16'd0, 32'd0, 5'd0, 10'd0, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] imm, input logic [31:0] pc, input logic [4:0] dest,
                       input logic [9:0] ctrl, input logic fl);
    exp_t        e;
    logic        tk;
    logic        is_mul;
    int unsigned stalls;
    drive(1'b1, op, a, b, imm, pc, dest, ctrl, fl);
    tk     = !fl && ctrl[9] && ((op == 6'd10 && a == b) || (op == 6'd11 && a != b));
    is_mul = !fl && (op == 6'd9);
    if (!fl) begin
      e.result     = alu_model(op, a, b, imm, ctrl[3]);
      e.chk_result = !(op == 6'd10 || op == 6'd11);
      e.store      = b;
      e.pc         = pc;
      e.dest       = dest;
      e.ctrl       = ctrl;
      if (tk) e.ctrl[2] = 1'b0;
      sb.push_back(e);
    end
    @(negedge clk);
    check("stall_on_issue", 32'(stall_out), 32'(is_mul));
    if (is_mul) begin
      stalls = 0;
      @(negedge clk);
      while (stall_out && stalls < MUL_CYCLES + 4) begin
        stalls++;
        @(negedge clk);
      end
      check("mul_busy_stall_cycles", stalls, MUL_CYCLES);
    end
    check("branch_taken", 32'(branch_taken), 32'(tk));
    if (tk) check("branch_target", branch_target, pc + 32'd1 + {{16{imm[15]}}, imm});
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid_out"}, 32'(valid_out), 32'd0);
    check({tag, "_result_out"}, result_out, 32'd0);
    check({tag, "_store_data_out"}, store_data_out, 32'd0);
    check({tag, "_dest_reg_out"}, 32'(dest_reg_out), 32'd0);
    check({tag, "_pc_out"}, pc_out, 32'd0);
    check({tag, "_ctrl_out"}, 32'(ctrl_out), 32'd0);
    check({tag, "_stall_out"}, 32'(stall_out), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  int unsigned r;
  logic [5:0]  r_op;
  logic [31:0] r_a, r_b, r_pc;
  logic [15:0] r_imm;
  logic [4:0]  r_dest;
  logic [9:0]  r_ctrl;
  logic        r_fl;

  initial begin
    rst = 1'b1;
    drive(1'b0, 6'd0, 32'd0, 32'd0, 16'd0, 32'd0, 5'd0, 10'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    mon_en = 1'b1;

    issue(6'd0, 32'd7, 32'd5, 16'd0, 32'h100, 5'd3, C_RW, 1'b0);
    check("add_result", result_out, 32'd12);
    issue(6'd7, 32'h8000_0000, 32'd4, 16'd0, 32'h104, 5'd4, C_RW, 1'b0);
    check("sra_result", result_out, 32'hF800_0000);
    issue(6'd8, 32'hFFFF_FFFF, 32'd1, 16'd0, 32'h108, 5'd5, C_RW, 1'b0);
    check("slt_result", result_out, 32'd1);

    issue(6'd9, 32'h0001_2345, 32'h0000_0100, 16'd0, 32'h10C, 5'd6, C_RW, 1'b0);
    check("mul_valid_out", 32'(valid_out), 32'd1);
    check("mul_result", result_out, 32'h0123_4500);
    issue(6'd0, 32'd1, 32'd2, 16'd0, 32'h110, 5'd7, C_RW, 1'b0);
    check("add_after_mul_valid", 32'(valid_out), 32'd1);
    check("add_after_mul_result", result_out, 32'd3);

    issue(6'd10, 32'd9, 32'd9, 16'hFFFC, 32'h40, 5'd1, C_BR | C_RW, 1'b0);
    issue(6'd10, 32'd9, 32'd8, 16'hFFFC, 32'h40, 5'd1, C_BR | C_RW, 1'b0);
    issue(6'd11, 32'd9, 32'd8, 16'h0010, 32'h80, 5'd1, C_BR, 1'b0);
    issue(6'h20, 32'h1000, 32'd0, 16'hFFF0, 32'h44, 5'd8, C_RW, 1'b0);
    issue(6'd0, 32'd0, 32'd0, 16'hABCD, 32'h48, 5'd9, C_LI | C_RW, 1'b0);
    check("load_imm_result", result_out, 32'hABCD_0000);

    // Flush a multiply ten cycles into its iterations.
    drive(1'b1, 6'd9, 32'd3, 32'd5, 16'd0, 32'h50, 5'd10, C_RW, 1'b0);
    @(negedge clk);
    check("flush_mul_accept_stall", 32'(stall_out), 32'd1);
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    check("flush_stall_drop", 32'(stall_out), 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 6'd0, 32'd0, 32'd0, 16'd0, 32'd0, 5'd0, 10'd0, 1'b0);
    @(negedge clk);
    check("flush_stall_after", 32'(stall_out), 32'd0);
    check("flush_bubble", 32'(valid_out), 32'd0);
    repeat (MUL_CYCLES + 4) bubble();
    issue(6'd1, 32'd50, 32'd8, 16'd0, 32'h54, 5'd11, C_RW, 1'b0);

    // Reset while the multiplier is busy.
    drive(1'b1, 6'd9, 32'd6, 32'd7, 16'd0, 32'h58, 5'd12, C_RW, 1'b0);
    @(negedge clk);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    drive(1'b1, 6'd0, 32'd7, 32'd5, 16'd0, 32'h5C, 5'd3, C_RW, 1'b0);
    @(posedge clk); #1;
    check_zero("rst_busy");
    rst = 1'b0;

    // Reset while a valid ADD sits in EX and the previous result is on the outputs.
    issue(6'd0, 32'd10, 32'd20, 16'd0, 32'h60, 5'd13, C_RW, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_zero("rst_add");
    rst = 1'b0;
    issue(6'd0, 32'd100, 32'd23, 16'd0, 32'h64, 5'd14, C_RW, 1'b0);
    check("post_reset_add", result_out, 32'd123);

    for (int i = 0; i < 200; i++) begin
      r      = $urandom_range(0, 19);
      r_op   = (r < 12) ? 6'(r) : 6'($urandom_range(12, 63));
      r_a    = $urandom;
      r_b    = ($urandom_range(0, 3) == 0) ? r_a : $urandom;
      r_imm  = 16'($urandom);
      r_pc   = $urandom;
      r_dest = 5'($urandom);
      r_ctrl = 10'($urandom);
      if (r_op == 6'd9) r_ctrl[3] = 1'b0;
      r_fl   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) bubble();
      else issue(r_op, r_a, r_b, r_imm, r_pc, r_dest, r_ctrl, r_fl);
    end

    repeat (3) bubble();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
